spi_ram_arbiter: RTL and testbench
==================================

# spi_ram_arbiter

Controller that owns the single-port RAM and shares it between the SPI slave command stream and a local host port. It decodes the 10-bit SPI command words (address/data) into RAM accesses and keeps separate write and read address latches. It arbitrates round-robin with the host, sequences each RAM access, and returns read data to whichever requester issued the read.

## Interface
- ADDR_SIZE, 8, RAM address and data width; SPI command word is ADDR_SIZE+2 bits.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- spi_rx_valid  in  1  one-cycle strobe, spi_rx_data valid
- spi_rx_data  in  ADDR_SIZE+2  [ADDR_SIZE+1:ADDR_SIZE]=cmd, [ADDR_SIZE-1:0]=payload
- spi_tx_valid  out  1  one-cycle strobe, spi_tx_data holds SPI read result
- spi_tx_data  out  ADDR_SIZE  SPI read data, holds until next SPI read completes
- spi_overflow  out  1  sticky, an SPI access command was dropped
- host_req  in  1  level request; host_we/addr/wdata stable while high until grant
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  ADDR_SIZE  host write data
- host_gnt  out  1  high for the single ACCESS cycle of a host access
- host_rvalid  out  1  one-cycle strobe, host_rdata holds read result
- host_rdata  out  ADDR_SIZE  host read data, holds until next host read completes
- ram_en, ram_we  out  1 each  RAM enable / write enable, registered
- ram_addr, ram_wdata  out  ADDR_SIZE  RAM address / write data, registered
- ram_rdata  in  ADDR_SIZE  RAM read data, valid the cycle after a read ram_en

## Operation
- Reset: state IDLE, every output 0, wr_addr/rd_addr latches 0, SPI pending buffer empty, last_winner=HOST (SPI wins the first tie).
- SPI decode on spi_rx_valid: cmd 00 → wr_addr<=payload; cmd 10 → rd_addr<=payload (no RAM access, no arbitration, applied on the strobe edge). cmd 01 → write request {we=1, addr=wr_addr, wdata=payload}; cmd 11 → read request {we=0, addr=rd_addr}, payload ignored. Latched address is captured at strobe time.
- SPI pending buffer: one entry. An access command is accepted if the buffer is empty or is being granted (IDLE→ACCESS) on the same edge; otherwise it is dropped and spi_overflow<=1 (cleared only by rst). Address commands never overflow.
- FSM: IDLE → ACCESS when SPI pending or host_req; ACCESS → IDLE on write, → RDATA on read; RDATA → IDLE always.
- Arbitration in IDLE only: one requester pending → it wins; both pending → the one not equal to last_winner wins; last_winner updates on grant. Requests arriving outside IDLE wait.
- On IDLE→ACCESS edge ram_en<=1, ram_we/addr/wdata <= winner's; SPI winner clears pending buffer. ram_en/ram_we return to 0 leaving ACCESS; ram_addr/ram_wdata hold.
- RDATA: ram_rdata captured at the RDATA→IDLE edge into spi_tx_data or host_rdata with the matching valid strobe high for the next cycle. spi_tx_valid and host_rvalid never high together.

## Timing
- SPI: spi_rx_valid in cycle 0 → pending cycle 1 → ram_en cycle 2 (if FSM idle and SPI wins) → read result spi_tx_valid cycle 4.
- Host: host_req sampled in IDLE cycle 0 → host_gnt and ram_en cycle 1 → read result host_rvalid cycle 3. Host may change inputs from cycle 2.
- Throughput: write 2 cycles/access, read 3 cycles/access (IDLE cycle between accesses).
- rst mid-access (any state): immediate return to reset values; in-flight read produces no valid strobe; pending request and address latches lost.
- Address command strobed while an SPI access is pending does not alter the pending request's address.

## Test plan
- SPI write: strobe 0x0A5 (cmd 00) then 0x13C (cmd 01) → cycle 2 after second strobe ram_en=1, ram_we=1, ram_addr=0xA5, ram_wdata=0x3C.
- SPI read: after above, strobe 0x2A5 then 0x300, RAM model returns 0x3C → ram_en=1, ram_we=0, ram_addr=0xA5 two cycles after second strobe; spi_tx_valid one cycle, spi_tx_data=0x3C, four cycles after strobe.
- Tie after reset: SPI write pending and host_req read addr 0x10 same IDLE cycle → SPI write first, host_gnt next IDLE; repeat tie → host served first.
- Overflow: host read in progress, two cmd-01 strobes on consecutive cycles → first kept, second dropped, spi_overflow=1, exactly one SPI RAM write.
- Reset mid-read: assert rst during RDATA → no spi_tx_valid/host_rvalid, all outputs 0, next cmd-01 writes to address 0x00.
- Host streaming: host_req held high, 4 writes changing after each host_gnt → host_gnt every 2 cycles, addresses/data in order.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Purpose: owns the single-port RAM and shares it round-robin between SPI command words and a local host port.
// Latency: SPI strobe to ram_en 2 cycles, to spi_tx_valid 4; host_req to host_gnt/ram_en 1 cycle, to host_rvalid 3.
// Backpressure: host holds host_req until host_gnt; one-entry SPI access buffer, excess SPI accesses dropped (sticky spi_overflow).
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_rx_valid,
    input  logic [ADDR_SIZE+1:0]   spi_rx_data,
    output logic                   spi_tx_valid,
    output logic [ADDR_SIZE-1:0]   spi_tx_data,
    output logic                   spi_overflow,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [ADDR_SIZE-1:0]   host_addr,
    input  logic [ADDR_SIZE-1:0]   host_wdata,
    output logic                   host_gnt,
    output logic                   host_rvalid,
    output logic [ADDR_SIZE-1:0]   host_rdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_SIZE-1:0]   ram_addr,
    output logic [ADDR_SIZE-1:0]   ram_wdata,
    input  logic [ADDR_SIZE-1:0]   ram_rdata
);

    // SPI command encodings: bit 0 set means RAM access, bit 1 set means read side.
    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Command word split.
    logic [1:0]           spi_cmd;
    logic [ADDR_SIZE-1:0] spi_payload;

    // Address latches loaded by the address commands.
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    // One-entry SPI access buffer; address is frozen when the command is accepted.
    logic                 pend_vld;
    logic                 pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [ADDR_SIZE-1:0] pend_wdata;

    // Fairness state: last_spi=1 when SPI won the previous grant.
    logic                 last_spi;
    // Owner of the access currently in flight, steers the read return.
    logic                 cur_spi;

    logic                 spi_is_access;
    logic                 grant_spi;
    logic                 grant_host;
    logic                 spi_accept;

    assign spi_cmd       = spi_rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign spi_payload   = spi_rx_data[ADDR_SIZE-1:0];
    assign spi_is_access = spi_rx_valid && ((spi_cmd == CMD_WRITE) || (spi_cmd == CMD_READ));

    // A new access fits if the buffer is empty or its occupant is leaving on this very edge.
    assign spi_accept    = spi_is_access && (!pend_vld || grant_spi);

    // Next-state and arbitration; grants only ever happen from IDLE.
    always_comb begin
        state_nxt  = state;
        grant_spi  = 1'b0;
        grant_host = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_vld && (!host_req || !last_spi)) begin
                    grant_spi = 1'b1;
                end else if (host_req) begin
                    grant_host = 1'b1;
                end
                if (grant_spi || grant_host) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // ram_we still describes the access being performed this cycle.
                state_nxt = ram_we ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address commands update their latch on the strobe edge and never touch the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (spi_rx_valid) begin
            if (spi_cmd == CMD_WADDR) begin
                wr_addr <= spi_payload;
            end else if (spi_cmd == CMD_RADDR) begin
                rd_addr <= spi_payload;
            end
        end
    end

    // SPI pending buffer: fill on accepted access, drain on SPI grant, flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld     <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            spi_overflow <= 1'b0;
        end else begin
            if (spi_accept) begin
                pend_vld <= 1'b1;
                if (spi_cmd == CMD_WRITE) begin
                    pend_we    <= 1'b1;
                    pend_addr  <= wr_addr;
                    pend_wdata <= spi_payload;
                end else begin
                    // Read payload carries nothing useful; keep the old write data.
                    pend_we    <= 1'b0;
                    pend_addr  <= rd_addr;
                end
            end else if (grant_spi) begin
                pend_vld <= 1'b0;
            end
            if (spi_is_access && !spi_accept) begin
                spi_overflow <= 1'b1;
            end
        end
    end

    // RAM command register: loaded on the IDLE->ACCESS edge, strobes drop when leaving ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            host_gnt  <= 1'b0;
            last_spi  <= 1'b0;
            cur_spi   <= 1'b0;
        end else if (grant_spi) begin
            ram_en    <= 1'b1;
            ram_we    <= pend_we;
            ram_addr  <= pend_addr;
            ram_wdata <= pend_wdata;
            host_gnt  <= 1'b0;
            last_spi  <= 1'b1;
            cur_spi   <= 1'b1;
        end else if (grant_host) begin
            ram_en    <= 1'b1;
            ram_we    <= host_we;
            ram_addr  <= host_addr;
            ram_wdata <= host_wdata;
            host_gnt  <= 1'b1;
            last_spi  <= 1'b0;
            cur_spi   <= 1'b0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            host_gnt  <= 1'b0;
        end
    end

    // Read return: capture RAM data leaving RDATA and strobe the owner's valid for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_tx_valid <= 1'b0;
            spi_tx_data  <= '0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
        end else begin
            spi_tx_valid <= 1'b0;
            host_rvalid  <= 1'b0;
            if (state == ST_RDATA) begin
                if (cur_spi) begin
                    spi_tx_valid <= 1'b1;
                    spi_tx_data  <= ram_rdata;
                end else begin
                    host_rvalid  <= 1'b1;
                    host_rdata   <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Purpose: directed bench for spi_ram_arbiter with a transaction-order model and a behavioural RAM.
// Latency: checks the documented strobe-to-access and access-to-result cycle counts at fixed points.
// Backpressure: host holds its request until host_gnt; SPI overflow scenario exercises the drop path.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_rx_valid;
    logic [9:0] spi_rx_data;
    logic       spi_tx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_overflow;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_overflow (spi_overflow),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM: read data appears the cycle after a read enable.
    logic       mem_init;
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Model: expected RAM accesses in order, and the read results each requester must see.
    typedef struct {
        bit         host;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } acc_t;

    acc_t       exp_acc[$];
    logic [7:0] exp_spi_rd[$];
    logic [7:0] exp_host_rd[$];
    logic [7:0] gold [256];
    acc_t       e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input bit host, input logic [7:0] a, input logic [7:0] d);
        exp_acc.push_back('{host, 1'b1, a, d});
        gold[a] = d;
    endtask

    task automatic push_rd(input bit host, input logic [7:0] a);
        exp_acc.push_back('{host, 1'b0, a, 8'h00});
        if (host) exp_host_rd.push_back(gold[a]);
        else      exp_spi_rd.push_back(gold[a]);
    endtask

    // Read whose result is expected to be lost (reset in flight).
    task automatic push_rd_lost(input bit host, input logic [7:0] a);
        exp_acc.push_back('{host, 1'b0, a, 8'h00});
    endtask

    task automatic spi_strobe(input logic [9:0] d);
        @(posedge clk); #1 spi_rx_valid = 1'b1; spi_rx_data = d;
        @(posedge clk); #1 spi_rx_valid = 1'b0;
    endtask

    task automatic wait_host_gnt();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (host_gnt) seen = 1'b1;
        end
        chk("host_gnt_wait", {31'd0, seen}, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_acc.size() == 0 && exp_spi_rd.size() == 0 && exp_host_rd.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("drain", exp_acc.size() + exp_spi_rd.size() + exp_host_rd.size(), 0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ram"},  {14'd0, ram_en, ram_we, ram_addr, ram_wdata}, 0);
        chk({tag, "_spi"},  {22'd0, spi_tx_valid, spi_overflow, spi_tx_data}, 0);
        chk({tag, "_host"}, {22'd0, host_gnt, host_rvalid, host_rdata}, 0);
    endtask

    // Compare process: every RAM access and read return is checked against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dual_rvalid", {31'd0, spi_tx_valid & host_rvalid}, 0);
            if (ram_en) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access_addr", {23'd0, ram_we, ram_addr}, 32'h1FF);
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_owner", {31'd0, host_gnt}, {31'd0, e.host});
                    chk("acc_we",    {31'd0, ram_we},   {31'd0, e.we});
                    chk("acc_addr",  {24'd0, ram_addr}, {24'd0, e.addr});
                    if (e.we) chk("acc_wdata", {24'd0, ram_wdata}, {24'd0, e.wdata});
                end
            end else begin
                chk("gnt_without_en", {31'd0, host_gnt}, 0);
            end
            if (spi_tx_valid) begin
                if (exp_spi_rd.size() == 0) chk("unexpected_spi_tx", {31'd0, spi_tx_valid}, 0);
                else chk("spi_rdata", {24'd0, spi_tx_data}, {24'd0, exp_spi_rd.pop_front()});
            end
            if (host_rvalid) begin
                if (exp_host_rd.size() == 0) chk("unexpected_host_rvalid", {31'd0, host_rvalid}, 0);
                else chk("host_rdata", {24'd0, host_rdata}, {24'd0, exp_host_rd.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_c = 0;
        rst = 1'b1; mem_init = 1'b1;
        spi_rx_valid = 1'b0; spi_rx_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'h5A;

        // Reset state.
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk); chk_outs_zero("rst");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk_outs_zero("post_rst");

        // SPI write: wr_addr=A5, write 3C; access two cycles after the second strobe.
        push_wr(0, 8'hA5, 8'h3C);
        spi_strobe(10'h0A5);
        spi_strobe(10'h13C);
        @(posedge clk); @(negedge clk);
        chk("spi_wr_cyc2", {14'd0, ram_en, ram_we, ram_addr, ram_wdata}, {14'd0, 1'b1, 1'b1, 8'hA5, 8'h3C});
        drain();

        // SPI read of A5: access at cycle 2, result strobe at cycle 4 only.
        push_rd(0, 8'hA5);
        spi_strobe(10'h2A5);
        spi_strobe(10'h300);
        @(posedge clk); @(negedge clk);
        chk("spi_rd_cyc2", {22'd0, ram_en, ram_we, ram_addr}, {22'd0, 1'b1, 1'b0, 8'hA5});
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("spi_rd_cyc4", {22'd0, spi_tx_valid, host_rvalid, spi_tx_data}, {22'd0, 1'b1, 1'b0, 8'h3C});
        @(posedge clk); @(negedge clk);
        chk("spi_rd_cyc5", {23'd0, spi_tx_valid, spi_tx_data}, {23'd0, 1'b0, 8'h3C});
        drain();

        // Tie after reset: SPI wins; a second SPI write then ties with the waiting host, host wins.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        spi_strobe(10'h020);
        push_wr(0, 8'h20, 8'h77);
        push_rd(1, 8'h10);
        push_wr(0, 8'h20, 8'h88);
        @(posedge clk); #1 spi_rx_valid = 1'b1; spi_rx_data = 10'h177;
        @(posedge clk); #1 spi_rx_valid = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        @(posedge clk); #1 spi_rx_valid = 1'b1; spi_rx_data = 10'h188;
        @(posedge clk); #1 spi_rx_valid = 1'b0;
        wait_host_gnt();
        @(posedge clk); #1 host_req = 1'b0;
        drain();

        // Overflow: two SPI writes while a host read is in flight, second one dropped.
        chk("ovf_before", {31'd0, spi_overflow}, 0);
        spi_strobe(10'h030);
        push_rd(1, 8'h40);
        push_wr(0, 8'h30, 8'h11);
        @(posedge clk); #1 host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        @(posedge clk); #1 spi_rx_valid = 1'b1; spi_rx_data = 10'h111;
        @(posedge clk); #1 host_req = 1'b0; spi_rx_data = 10'h122;
        @(posedge clk); #1 spi_rx_valid = 1'b0;
        @(negedge clk); chk("ovf_set", {31'd0, spi_overflow}, 1);
        drain();
        chk("ovf_sticky", {31'd0, spi_overflow}, 1);

        // Reset during RDATA of an SPI read: no result, outputs cleared, latches cleared.
        push_rd_lost(0, 8'h50);
        spi_strobe(10'h250);
        spi_strobe(10'h300);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); chk_outs_zero("mid_rst");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_valid", {30'd0, spi_tx_valid, host_rvalid}, 0);
        push_wr(0, 8'h00, 8'h5E);
        spi_strobe(10'h15E);
        drain();

        // Host streaming: four writes, one grant every two cycles.
        for (int i = 0; i < 4; i++) push_wr(1, 8'(8'h60 + i), 8'(8'hC0 + i));
        @(posedge clk); #1 host_req = 1'b1; host_we = 1'b1; host_addr = 8'h60; host_wdata = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            wait_host_gnt();
            if (i > 0) chk("stream_gap", cyc - last_c, 2);
            last_c = cyc;
            @(posedge clk); #1;
            if (i < 3) begin
                host_addr  = 8'(8'h60 + i + 1);
                host_wdata = 8'(8'hC0 + i + 1);
            end else begin
                host_req = 1'b0;
            end
        end
        drain();

        // Host read back of a streamed word: grant at cycle 1, result at cycle 3.
        push_rd(1, 8'h62);
        @(posedge clk); #1 host_req = 1'b1; host_we = 1'b0; host_addr = 8'h62;
        @(negedge clk); chk("host_rd_cyc0", {31'd0, host_gnt}, 0);
        @(posedge clk); @(negedge clk); chk("host_rd_cyc1", {30'd0, host_gnt, ram_en}, 3);
        @(posedge clk); #1 host_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("host_rd_cyc3", {23'd0, host_rvalid, host_rdata}, {23'd0, 1'b1, 8'hC2});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
